// File: rtl/ppcm_write_nexys3_pkg.sv
// ppcm_write_nexys3_pkg: opcodes, status bits, states and timing helpers for the P-PCM writer.
// PPCM_UNLOCK_EN adds the block-unlock states S_UNLK1/S_UNLK2.
package ppcm_write_nexys3_pkg;
  localparam logic [15:0] CMD_PROG  = 16'h0040;
  localparam logic [15:0] CMD_CLRSR = 16'h0050;
  localparam logic [15:0] CMD_UNLK  = 16'h0060;
  localparam logic [15:0] CMD_CONF  = 16'h00D0;
  localparam logic [15:0] CMD_RDARR = 16'h00FF;
  localparam int SR_RDY  = 7;
  localparam int SR_PROG = 4;
  localparam int SR_VPP  = 3;
  localparam int SR_LOCK = 1;
  typedef enum logic [3:0] {
    S_INIT, S_IDLE,
`ifdef PPCM_UNLOCK_EN
    S_UNLK1, S_UNLK2,
`endif
    S_CMD, S_DATA, S_POLL, S_CLR, S_RDARR, S_DONE
  } state_t;
  localparam state_t S_FIRST =
`ifdef PPCM_UNLOCK_EN
    S_UNLK1;
`else
    S_CMD;
`endif
  typedef enum logic [2:0] {P_IDLE, P_SETUP, P_PULSE, P_HOLD, P_RD, P_REC} phase_t;
  function automatic int get_width(input int x);
    return x < 1 ? 1 : $clog2(x + 1);
  endfunction
  function automatic int count_of(input int freq, input int delay);
    return 1 + freq * delay / 1000;
  endfunction
endpackage

// File: rtl/ppcm_write_nexys3_bus_cycle.sv
// ppcm_write_nexys3_bus_cycle: one timed P-PCM write (setup/pulse/hold) or status read (access/recover).
module ppcm_write_nexys3_bus_cycle
  import ppcm_write_nexys3_pkg::*;
#(
  parameter int AW   = 23,
  parameter int C_WP = 7,
  parameter int C_WH = 4,
  parameter int C_RD = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_read,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  input  logic [15:0]   pcm_din,
  output logic          done,
  output logic [15:0]   rdata,
  output logic          ce_n,
  output logic          oe_n,
  output logic          we_n,
  output logic          dout_en,
  output logic [AW-1:0] pcm_addr,
  output logic [15:0]   pcm_dout
);
  localparam int CMAX = C_RD > C_WP ? (C_RD > C_WH ? C_RD : C_WH) : (C_WP > C_WH ? C_WP : C_WH);
  localparam int CW = get_width(CMAX);
  localparam logic [CW-1:0] L_WP = CW'(C_WP - 1);
  localparam logic [CW-1:0] L_WH = CW'(C_WH - 1);
  localparam logic [CW-1:0] L_RD = CW'(C_RD - 1);
  phase_t phase, phase_nx;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase <= P_IDLE;
    else phase <= phase_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      rdata <= '0;
      pcm_addr <= '0;
      pcm_dout <= '0;
    end else begin
      if (phase_nx != phase) cnt <= '0;
      else if (cnt != CW'(CMAX)) cnt <= cnt + CW'(1);
      if (phase == P_IDLE && start) pcm_addr <= addr;
      if (phase == P_IDLE && start && !is_read) pcm_dout <= wdata;
      if (phase == P_RD && cnt == L_RD) rdata <= pcm_din;
    end
  always_comb begin
    phase_nx = phase;
    case (phase)
      P_IDLE:  if (start) phase_nx = is_read ? P_RD : P_SETUP;
      P_SETUP: phase_nx = P_PULSE;
      P_PULSE: if (cnt == L_WP) phase_nx = P_HOLD;
      P_HOLD:  if (cnt == L_WH) phase_nx = P_IDLE;
      P_RD:    if (cnt == L_RD) phase_nx = P_REC;
      default: phase_nx = P_IDLE;
    endcase
  end
  // Data pads are driven only in write phases, output enable only in read phases, so they never overlap.
  always_comb begin
    done    = (phase == P_HOLD && cnt == L_WH) || phase == P_REC;
    ce_n    = !(phase inside {P_SETUP, P_PULSE, P_RD});
    oe_n    = phase != P_RD;
    we_n    = phase != P_PULSE;
    dout_en = phase inside {P_SETUP, P_PULSE, P_HOLD};
  end
endmodule

// File: rtl/ppcm_write_nexys3.sv
// ppcm_write_nexys3: programs a 32-bit word into P-PCM as two 16-bit halves, polls status, restores read-array.
// Define PPCM_UNLOCK_EN to unlock the block (0x60, 0xD0) before each half.
module ppcm_write_nexys3
  import ppcm_write_nexys3_pkg::*;
#(
  parameter int CLK_FREQ   = 100,
  parameter int ADDR_BITS  = 24,
  parameter int DELAY_INIT = 100000,
  parameter int DELAY_WP   = 60,
  parameter int DELAY_WH   = 30,
  parameter int DELAY_RD   = 115,
  parameter int POLL_MAX   = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic [ADDR_BITS-3:0] addr,
  input  logic [31:0]          din,
  output logic                 busy,
  output logic                 ack,
  output logic                 err,
  output logic                 pcm_ce_n,
  output logic                 pcm_rst_n,
  output logic                 pcm_oe_n,
  output logic                 pcm_we_n,
  output logic [ADDR_BITS-2:0] pcm_addr,
  input  logic [15:0]          pcm_din,
  output logic [15:0]          pcm_dout,
  output logic                 pcm_dout_en
);
  localparam int C_INIT = count_of(CLK_FREQ, DELAY_INIT);
  localparam int IW = get_width(C_INIT - 1);
  localparam int PW = get_width(POLL_MAX);
  state_t state, state_nx;
  logic [IW-1:0] init_cnt;
  logic [PW-1:0] poll_cnt;
  logic [ADDR_BITS-3:0] addr_q;
  logic [31:0] din_q;
  logic [15:0] wdata, rdata;
  logic half, pending, start, done, is_read, init_done, sr_err, timeout;
  assign init_done = init_cnt == IW'(C_INIT - 1);
  assign sr_err = rdata[SR_RDY] & (rdata[SR_PROG] | rdata[SR_VPP] | rdata[SR_LOCK]);
  assign timeout = !rdata[SR_RDY] && poll_cnt == PW'(POLL_MAX - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_INIT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (init_done) state_nx = S_IDLE;
      S_IDLE:  if (cs) state_nx = S_FIRST;
`ifdef PPCM_UNLOCK_EN
      S_UNLK1: if (done) state_nx = S_UNLK2;
      S_UNLK2: if (done) state_nx = S_CMD;
`endif
      S_CMD:   if (done) state_nx = S_DATA;
      S_DATA:  if (done) state_nx = S_POLL;
      S_POLL:  if (done) state_nx = !rdata[SR_RDY] ? (timeout ? S_CLR : S_POLL) :
                                    sr_err ? S_CLR : half ? S_RDARR : S_FIRST;
      S_CLR:   if (done) state_nx = S_RDARR;
      S_RDARR: if (done) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      init_cnt <= '0;
      poll_cnt <= '0;
      pcm_rst_n <= 1'b0;
      pending <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      half <= 1'b0;
      err <= 1'b0;
    end else begin
      pcm_rst_n <= 1'b1;
      pending <= start | (pending & ~done);
      if (state == S_INIT && !init_done) init_cnt <= init_cnt + IW'(1);
      if (state == S_DATA) poll_cnt <= '0;
      else if (state == S_POLL && done && !rdata[SR_RDY] && poll_cnt != PW'(POLL_MAX)) poll_cnt <= poll_cnt + PW'(1);
      if (state == S_IDLE && cs) begin
        addr_q <= addr;
        din_q <= din;
        half <= 1'b0;
        err <= 1'b0;
      end
      if (state == S_POLL && done) begin
        if (timeout || sr_err) err <= 1'b1;
        else if (rdata[SR_RDY]) half <= 1'b1;
      end
    end
  always_comb begin
    busy    = state != S_IDLE;
    ack     = state == S_DONE;
    start   = !(state inside {S_INIT, S_IDLE, S_DONE}) && !pending;
    is_read = state == S_POLL;
    wdata   = state == S_CMD   ? CMD_PROG :
              state == S_DATA  ? (half ? din_q[31:16] : din_q[15:0]) :
              state == S_CLR   ? CMD_CLRSR :
              state == S_RDARR ? CMD_RDARR :
`ifdef PPCM_UNLOCK_EN
              state == S_UNLK1 ? CMD_UNLK :
              state == S_UNLK2 ? CMD_CONF :
`endif
              16'h0000;
  end
  ppcm_write_nexys3_bus_cycle #(
    .AW(ADDR_BITS - 1),
    .C_WP(count_of(CLK_FREQ, DELAY_WP)),
    .C_WH(count_of(CLK_FREQ, DELAY_WH)),
    .C_RD(count_of(CLK_FREQ, DELAY_RD))
  ) u_bus (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_read(is_read),
    .addr({addr_q, half}),
    .wdata(wdata),
    .pcm_din(pcm_din),
    .done(done),
    .rdata(rdata),
    .ce_n(pcm_ce_n),
    .oe_n(pcm_oe_n),
    .we_n(pcm_we_n),
    .dout_en(pcm_dout_en),
    .pcm_addr(pcm_addr),
    .pcm_dout(pcm_dout)
  );
endmodule
